// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - MEM stage types and control-field indices
package mem_stage_pkg;
`include "pipeline_defs.vh"

    localparam int M_BRANCH_BIT   = `M_BRANCH;
    localparam int M_MEMREAD_BIT  = `M_MEMREAD;
    localparam int M_MEMWRITE_BIT = `M_MEMWRITE;
    localparam int M_JUMP_BIT     = `M_JUMP;
    localparam int LAT_DEFAULT    = `MEM_LAT_DEFAULT;

    typedef enum logic {
        IDLE   = `ST_IDLE,
        ACCESS = `ST_ACCESS
    } mem_state_t;
endpackage

// File: rtl/memoria_datos.sv
// rtl/memoria_datos.sv - data memory array, synchronous write, asynchronous read
module memoria_datos #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);
    logic [31:0] mem [2**DEPTH_LOG2];

    // No reset: contents persist across pipeline resets.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/pipeline_defs.vh
// rtl/pipeline_defs.vh - shared pipeline control bit indices, MEM FSM encodings, default memory latency
`ifndef PIPELINE_DEFS_VH
`define PIPELINE_DEFS_VH

`define WB_REGWRITE     1
`define WB_MEMTOREG     0

`define M_BRANCH        3
`define M_MEMREAD       2
`define M_MEMWRITE      1
`define M_JUMP          0

`define ST_IDLE         1'b0
`define ST_ACCESS       1'b1

`define MEM_LAT_DEFAULT 2

`endif

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: multi-cycle data access FSM, branch resolve, MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_LAT    = LAT_DEFAULT,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [1:0]  wb,
    input  logic [3:0]  m,
    input  logic [31:0] add2,
    input  logic [31:0] resulalu,
    input  logic [31:0] rd2,
    input  logic [4:0]  mux,
    input  logic        zero,
    input  logic [31:0] instTipoJ,
    output logic        stall,
    output logic        pcsrc,
    output logic [31:0] pc_target,
    output logic [1:0]  salida_wb,
    output logic [31:0] salida_datomem,
    output logic [31:0] salida_resulalu,
    output logic [4:0]  salida_mux,
    output logic        out_valid,
    output logic        misalign
);
    mem_state_t  state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        memop, aligned, mem_we, load, mis_next;
    logic [31:0] rdata, dat_next;
    logic        unused_addr_hi;

    assign memop   = in_valid & (m[M_MEMREAD_BIT] | m[M_MEMWRITE_BIT]);
    assign aligned = (resulalu[1:0] == 2'b00);
    assign unused_addr_hi = ^resulalu[31:DEPTH_LOG2+2];

    memoria_datos #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (resulalu[DEPTH_LOG2+1:2]),
        .wdata (rd2),
        .rdata (rdata)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        mem_we     = 1'b0;
        load       = 1'b0;
        mis_next   = 1'b0;
        dat_next   = 32'd0;
        case (state)
            IDLE: begin
                if (memop && aligned) begin
                    stall      = 1'b1;
                    state_next = ACCESS;
                    cnt_next   = 4'(MEM_LAT - 1);
                end else if (memop) begin
                    mis_next = 1'b1;
                end else if (in_valid) begin
                    load = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt != 4'd0) begin
                    stall    = 1'b1;
                    cnt_next = cnt - 4'd1;
                end else begin
                    // Final cycle: commit the write and hand the result to MEM/WB.
                    mem_we     = m[M_MEMWRITE_BIT];
                    load       = 1'b1;
                    dat_next   = m[M_MEMWRITE_BIT] ? rd2 : rdata;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Reset aborts any access in flight, including its pending write.
        if (!rst_n) begin
            stall  = 1'b0;
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            out_valid       <= 1'b0;
            misalign        <= 1'b0;
            salida_wb       <= 2'd0;
            salida_datomem  <= 32'd0;
            salida_resulalu <= 32'd0;
            salida_mux      <= 5'd0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            out_valid       <= load;
            misalign        <= mis_next;
            salida_wb       <= load ? wb : 2'd0;
            salida_datomem  <= dat_next;
            salida_resulalu <= load ? resulalu : 32'd0;
            salida_mux      <= load ? mux : 5'd0;
        end
    end

    assign pcsrc     = rst_n & in_valid & ~stall & ((m[M_BRANCH_BIT] & zero) | m[M_JUMP_BIT]);
    assign pc_target = m[M_JUMP_BIT] ? instTipoJ : add2;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard testbench for mem_stage
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  wb;
    logic [3:0]  m;
    logic [31:0] add2, resulalu, rd2, instTipoJ;
    logic [4:0]  mux;
    logic        zero;
    logic        stall, pcsrc, out_valid, misalign;
    logic [31:0] pc_target, salida_datomem, salida_resulalu;
    logic [1:0]  salida_wb;
    logic [4:0]  salida_mux;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] dat;
        logic [31:0] res;
        logic [4:0]  mx;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    mem_stage #(.MEM_LAT(2), .DEPTH_LOG2(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .wb(wb), .m(m),
        .add2(add2), .resulalu(resulalu), .rd2(rd2), .mux(mux), .zero(zero),
        .instTipoJ(instTipoJ), .stall(stall), .pcsrc(pcsrc), .pc_target(pc_target),
        .salida_wb(salida_wb), .salida_datomem(salida_datomem),
        .salida_resulalu(salida_resulalu), .salida_mux(salida_mux),
        .out_valid(out_valid), .misalign(misalign)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every valid MEM/WB word must match the oldest expectation.
    always @(negedge clk) begin
        if (out_valid !== 1'b0) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_wb",      {30'd0, salida_wb}, {30'd0, e.wb});
                chk("sb_datomem", salida_datomem, e.dat);
                chk("sb_resulalu", salida_resulalu, e.res);
                chk("sb_mux",     {27'd0, salida_mux}, {27'd0, e.mx});
                chk("sb_latency", cyc, e.cyc);
            end
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        m        = 4'd0;
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [1:0] w, input logic [3:0] mm, input logic [31:0] a2,
                         input logic [31:0] r, input logic [31:0] d, input logic [4:0] mx,
                         input logic z, input logic [31:0] j, input bit expv,
                         input logic [31:0] expd, input int lat, output int nst,
                         output logic pcs, output logic [31:0] pct);
        logic s;
        in_valid = 1'b1; wb = w; m = mm; add2 = a2; resulalu = r; rd2 = d;
        mux = mx; zero = z; instTipoJ = j;
        if (expv) sb.push_back('{w, expd, r, mx, cyc + lat});
        nst = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            s = stall;
            if (k == 0) begin
                pcs = pcsrc;
                pct = pc_target;
            end
            @(posedge clk); #1;
            if (s !== 1'b1) break;
            nst++;
        end
        if (nst >= 39) chk("stall_timeout", nst, 0);
    endtask

    initial begin
        int n;
        logic p;
        logic [31:0] t;

        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic p;
        logic [31:0] t;

        rst_n = 1'b0; in_valid = 1'b1; wb = 2'b11; m = 4'b0001; add2 = 32'h4;
        resulalu = 32'h10; rd2 = 32'h0; mux = 5'd3; zero = 1'b1; instTipoJ = 32'h80;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_pcsrc", {31'd0, pcsrc}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_salida_wb", {30'd0, salida_wb}, 32'd0);
        chk("rst_salida_datomem", salida_datomem, 32'd0);
        chk("rst_salida_resulalu", salida_resulalu, 32'd0);
        chk("rst_salida_mux", {27'd0, salida_mux}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();

        // Store then load of the same word.
        issue(2'b01, 4'b0010, 32'h0, 32'h10, 32'hDEADBEEF, 5'd4, 1'b0, 32'h0, 1, 32'hDEADBEEF, 3, n, p, t);
        chk("store_stall_cycles", n, 2);
        idle();
        issue(2'b11, 4'b0100, 32'h0, 32'h10, 32'h0, 5'd9, 1'b0, 32'h0, 1, 32'hDEADBEEF, 3, n, p, t);
        chk("load_stall_cycles", n, 2);

        // Read+write together, followed immediately by a read of that word.
        issue(2'b10, 4'b0110, 32'h0, 32'h18, 32'h12345678, 5'd7, 1'b0, 32'h0, 1, 32'h12345678, 3, n, p, t);
        chk("rw_stall_cycles", n, 2);
        issue(2'b11, 4'b0100, 32'h0, 32'h18, 32'h0, 5'd8, 1'b0, 32'h0, 1, 32'h12345678, 3, n, p, t);
        chk("raw_stall_cycles", n, 2);

        // Branch / jump resolution.
        issue(2'b00, 4'b1000, 32'h40, 32'h0, 32'h0, 5'd0, 1'b1, 32'h80, 1, 32'h0, 1, n, p, t);
        chk("br_taken_pcsrc", {31'd0, p}, 32'd1);
        chk("br_taken_target", t, 32'h40);
        chk("br_stall_cycles", n, 0);
        issue(2'b00, 4'b1000, 32'h40, 32'h1, 32'h0, 5'd0, 1'b0, 32'h80, 1, 32'h0, 1, n, p, t);
        chk("br_not_taken_pcsrc", {31'd0, p}, 32'd0);
        issue(2'b00, 4'b1001, 32'h40, 32'h2, 32'h0, 5'd0, 1'b1, 32'h80, 1, 32'h0, 1, n, p, t);
        chk("jump_pcsrc", {31'd0, p}, 32'd1);
        chk("jump_target", t, 32'h80);

        // Misaligned store: no stall, one-cycle misalign, bubble, memory intact.
        issue(2'b00, 4'b0010, 32'h0, 32'h13, 32'h00000BAD, 5'd0, 1'b0, 32'h0, 0, 32'h0, 0, n, p, t);
        chk("mis_stall_cycles", n, 0);
        in_valid = 1'b0; m = 4'd0;
        @(negedge clk);
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mis_pulse_end", {31'd0, misalign}, 32'd0);
        @(posedge clk); #1;
        issue(2'b11, 4'b0100, 32'h0, 32'h10, 32'h0, 5'd2, 1'b0, 32'h0, 1, 32'hDEADBEEF, 3, n, p, t);

        // Reset in the last access cycle must drop the store to word 8.
        issue(2'b00, 4'b0010, 32'h0, 32'h20, 32'h11111111, 5'd0, 1'b0, 32'h0, 1, 32'h11111111, 3, n, p, t);
        in_valid = 1'b1; wb = 2'b00; m = 4'b0010; resulalu = 32'h20; rd2 = 32'h22222222;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0; m = 4'd0;
        @(negedge clk);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_datomem", salida_datomem, 32'd0);
        chk("abort_stall_after", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;

        // Back-to-back ALU ops: single-cycle, never stall.
        issue(2'b10, 4'b0000, 32'h0, 32'h5, 32'h0, 5'd5, 1'b0, 32'h0, 1, 32'h0, 1, n, p, t);
        chk("alu1_stall_cycles", n, 0);
        issue(2'b10, 4'b0000, 32'h0, 32'h6, 32'h0, 5'd6, 1'b0, 32'h0, 1, 32'h0, 1, n, p, t);
        chk("alu2_stall_cycles", n, 0);
        issue(2'b11, 4'b0100, 32'h0, 32'h20, 32'h0, 5'd1, 1'b0, 32'h0, 1, 32'h11111111, 3, n, p, t);

        // Upper address bits wrap: 0x110 maps to word 4.
        issue(2'b11, 4'b0100, 32'h0, 32'h110, 32'h0, 5'd10, 1'b0, 32'h0, 1, 32'hDEADBEEF, 3, n, p, t);
        idle(); idle(); idle();
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
